// File: rtl/genius_input_checker.sv
// Player-side checker for the Genius (Simon) game: walks the sequence RAM and
// compares each stored colour against debounced, one-hot presses on KEY.
module genius_input_checker #(
   parameter int DEB_CYCLES     = 500000,
   parameter int TIMEOUT_CYCLES = 150000000,
   parameter int ADDR_W         = 5
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic [3:0]        KEY,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] seq_addr,
   input  logic [1:0]        seq_data,
   output logic              busy,
   output logic              round_ok,
   output logic              round_err,
   output logic              timeout,
   output logic [3:0]        press_led,
   output logic [ADDR_W:0]   progress
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
   localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      WAIT_PRESS,
      DEB_PRESS,
      COMPARE,
      WAIT_RELEASE,
      DEB_RELEASE,
      SUCCESS,
      FAIL
   } state_t;

   state_t state, state_next;

   logic [3:0]       key_s1, key_s2;
   logic [3:0]       k;
   logic             k_onehot;
   logic [3:0]       cand;
   logic [1:0]       exp_colour;
   logic [3:0]       exp_onehot;
   logic [ADDR_W:0]  len_r;
   logic [ADDR_W:0]  idx;
   logic [ADDR_W:0]  idx_inc;
   logic             fetch_phase;
   logic [DEB_W-1:0] dcnt;
   logic [TO_W-1:0]  tcnt;
   logic             deb_done;
   logic             to_hit;

   // Synchroniser resets to "all released" so no phantom press follows reset.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_s1 <= 4'hF;
         key_s2 <= 4'hF;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
      end
   end

   assign k          = ~key_s2;
   assign k_onehot   = (k != 4'd0) && ((k & (k - 4'd1)) == 4'd0);
   assign exp_onehot = 4'b0001 << exp_colour;
   assign idx_inc    = idx + IDX_ONE;
   assign deb_done   = (dcnt == DEB_LAST);
   assign to_hit     = (tcnt == TO_LAST);
   assign seq_addr   = idx[ADDR_W-1:0];

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      round_ok   = 1'b0;
      round_err  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = (len == '0) ? SUCCESS : FETCH;
         end
         FETCH: begin
            busy = 1'b1;
            if (fetch_phase) state_next = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            busy = 1'b1;
            if (to_hit)        state_next = FAIL;
            else if (k_onehot) state_next = DEB_PRESS;
         end
         DEB_PRESS: begin
            busy = 1'b1;
            if (k != cand)     state_next = WAIT_PRESS;
            else if (deb_done) state_next = COMPARE;
         end
         COMPARE: begin
            busy       = 1'b1;
            state_next = (cand == exp_onehot) ? WAIT_RELEASE : FAIL;
         end
         WAIT_RELEASE: begin
            busy = 1'b1;
            if (k == 4'd0) state_next = DEB_RELEASE;
         end
         DEB_RELEASE: begin
            busy = 1'b1;
            if (k != 4'd0)     state_next = WAIT_RELEASE;
            else if (deb_done) state_next = (idx_inc == len_r) ? SUCCESS : FETCH;
         end
         SUCCESS: begin
            round_ok   = 1'b1;
            state_next = IDLE;
         end
         FAIL: begin
            round_err  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FETCH spends one cycle addressing the RAM and one capturing its data.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         len_r       <= '0;
         idx         <= '0;
         progress    <= '0;
         timeout     <= 1'b0;
         press_led   <= 4'd0;
         cand        <= 4'd0;
         exp_colour  <= 2'd0;
         fetch_phase <= 1'b0;
         dcnt        <= '0;
         tcnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_r       <= len;
                  idx         <= '0;
                  progress    <= '0;
                  timeout     <= 1'b0;
                  fetch_phase <= 1'b0;
               end
            end
            FETCH: begin
               fetch_phase <= ~fetch_phase;
               if (fetch_phase) begin
                  exp_colour <= seq_data;
                  tcnt       <= '0;
               end
            end
            WAIT_PRESS: begin
               tcnt <= tcnt + TO_ONE;
               if (to_hit) begin
                  timeout <= 1'b1;
               end else if (k_onehot) begin
                  cand <= k;
                  dcnt <= '0;
               end
            end
            DEB_PRESS: begin
               if (k == cand) dcnt <= dcnt + DEB_ONE;
            end
            COMPARE: begin
               if (cand == exp_onehot) press_led <= cand;
            end
            WAIT_RELEASE: begin
               dcnt <= '0;
            end
            DEB_RELEASE: begin
               dcnt <= dcnt + DEB_ONE;
               if (k == 4'd0 && deb_done) begin
                  press_led <= 4'd0;
                  idx       <= idx_inc;
                  if (progress < len_r) progress <= progress + IDX_ONE;
               end
            end
            FAIL: begin
               press_led <= 4'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_genius_input_checker.sv
// Scoreboard bench for genius_input_checker: a round-level model predicts each
// round's outcome, and a monitor checks every round_ok/round_err pulse against it.
module tb_genius_input_checker;

   localparam int DEB    = 4;
   localparam int TO     = 100;
   localparam int ADDR_W = 3;

   logic              CLOCK_50;
   logic              RESET;
   logic [3:0]        KEY;
   logic              start;
   logic [ADDR_W:0]   len;
   logic [ADDR_W-1:0] seq_addr;
   logic [1:0]        seq_data;
   logic              busy;
   logic              round_ok;
   logic              round_err;
   logic              timeout;
   logic [3:0]        press_led;
   logic [ADDR_W:0]   progress;

   genius_input_checker #(
      .DEB_CYCLES(DEB),
      .TIMEOUT_CYCLES(TO),
      .ADDR_W(ADDR_W)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .KEY(KEY),
      .start(start),
      .len(len),
      .seq_addr(seq_addr),
      .seq_data(seq_data),
      .busy(busy),
      .round_ok(round_ok),
      .round_err(round_err),
      .timeout(timeout),
      .press_led(press_led),
      .progress(progress)
   );

   typedef struct {
      logic ok;
      logic to;
      int   prog;
   } exp_t;

   // Step kinds: 0 clean correct press, 1 wrong colour, 2 no press (timeout),
   // 3 bouncy correct press, 4 two keys then one released.
   localparam int K_OK = 0, K_WRONG = 1, K_TIMEOUT = 2, K_BOUNCE = 3, K_DOUBLE = 4;

   exp_t       sb_q[$];
   logic [1:0] ram [0:7];
   int         plan [8];
   int         tests;
   int         errors;
   logic [3:0] prev_led;

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) seq_data <= ram[seq_addr];

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      tests++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   always @(negedge CLOCK_50) begin
      if (!RESET) begin
         if (round_ok || round_err) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_pulse", {round_ok, round_err}, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checkOutput("outcome_ok_err", {round_ok, round_err}, e.ok ? 2 : 1);
               checkOutput("outcome_timeout", timeout, e.to);
               checkOutput("outcome_progress", progress, e.prog);
               checkOutput("outcome_busy_low", busy, 0);
            end
         end
         if (press_led != prev_led && press_led != 4'd0)
            checkOutput("press_led", press_led, 1 << ram[progress[2:0]]);
      end
      prev_led = press_led;
   end

   task automatic applyStimulus(input int len_v);
      exp_t       e;
      int         prog_m;
      int         colour;
      int         other;
      int         hold;
      int         rel;
      int         n;
      logic [3:0] oh;

      e.ok   = 1'b1;
      e.to   = 1'b0;
      prog_m = 0;
      for (int i = 0; i < len_v; i++) begin
         if (plan[i] == K_WRONG)   begin e.ok = 1'b0; break; end
         if (plan[i] == K_TIMEOUT) begin e.ok = 1'b0; e.to = 1'b1; break; end
         prog_m++;
      end
      e.prog = prog_m;
      sb_q.push_back(e);

      KEY   = 4'hF;
      len   = (ADDR_W + 1)'(len_v);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      if (len_v > 0) checkOutput("busy_after_start", busy, 1);

      for (int i = 0; i < len_v; i++) begin
         colour = int'(ram[i]);
         oh     = 4'b0001 << colour;
         other  = (colour + 1 + $urandom_range(0, 2)) % 4;
         hold   = $urandom_range(10, 14);
         rel    = $urandom_range(12, 20);
         if (plan[i] == K_TIMEOUT) break;
         case (plan[i])
            K_WRONG: begin
               KEY = ~(4'b0001 << other);
               tick(hold);
            end
            K_BOUNCE: begin
               KEY = ~oh;  tick(2);
               KEY = 4'hF; tick(1);
               KEY = ~oh;  tick(hold);
            end
            K_DOUBLE: begin
               KEY = ~(oh | (4'b0001 << other));
               tick(3);
               KEY = ~oh;
               tick(hold);
            end
            default: begin
               KEY = ~oh;
               tick(3);
               if ($urandom_range(0, 3) == 0) begin
                  len   = (ADDR_W + 1)'($urandom_range(0, 8));
                  start = 1'b1;
                  tick(1);
                  start = 1'b0;
               end
               tick(hold);
            end
         endcase
         KEY = 4'hF;
         tick(rel);
         if (plan[i] == K_WRONG) break;
      end

      n = 0;
      while (busy && n < 400) begin
         tick(1);
         n++;
      end
      checkOutput("round_done_busy", busy, 0);
      tick(2);
      checkOutput("timeout_hold", timeout, e.to);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tests    = 0;
      errors   = 0;
      prev_led = 4'd0;
      KEY      = 4'hF;
      start    = 1'b0;
      len      = '0;
      RESET    = 1'b1;
      foreach (ram[i]) ram[i] = 2'd0;
      ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
      tick(3);
      checkOutput("reset_outputs",
                  {busy, round_ok, round_err, timeout, press_led, progress, seq_addr}, 0);
      RESET = 1'b0;
      tick(2);

      // Directed rounds on sequence {2,0,3}
      plan = '{K_OK, K_OK, K_OK, K_OK, K_OK, K_OK, K_OK, K_OK};
      applyStimulus(3);
      plan[1] = K_WRONG;
      applyStimulus(2);
      plan[0] = K_TIMEOUT;
      applyStimulus(1);
      plan[0] = K_BOUNCE;
      applyStimulus(1);
      plan[0] = K_DOUBLE;
      applyStimulus(1);

      // Reset while a key is held aborts the round silently
      len   = 4'd3;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      KEY   = ~(4'b0001 << ram[0]);
      tick(12);
      checkOutput("led_before_reset", press_led, 1 << ram[0]);
      RESET = 1'b1;
      #1;
      checkOutput("reset_mid_round",
                  {busy, round_ok, round_err, timeout, press_led, progress, seq_addr}, 0);
      KEY = 4'hF;
      tick(2);
      RESET = 1'b0;
      tick(3);
      applyStimulus(0);

      // Randomised rounds
      for (int r = 0; r < 25; r++) begin
         foreach (ram[i]) ram[i] = 2'($urandom_range(0, 3));
         for (int s = 0; s < 8; s++) begin
            int x;
            x = $urandom_range(0, 19);
            if (x < 14)       plan[s] = K_OK;
            else if (x < 16)  plan[s] = K_BOUNCE;
            else if (x < 18)  plan[s] = K_DOUBLE;
            else if (x == 18) plan[s] = K_WRONG;
            else              plan[s] = K_TIMEOUT;
         end
         applyStimulus($urandom_range(0, 8));
      end

      tick(5);
      checkOutput("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/genius_input_checker.md
Name: genius_input_checker

Overview:
- Player-side reader for the Genius (Simon) game: plays back nothing, reads what the player presses.
- The sequence-display block writes and shows the colour sequence. This block reads the same sequence RAM and compares it against debounced presses on the board KEY buttons.
- Reports round success, wrong colour or timeout to the game controller in Topo.

Parameters:
- DEB_CYCLES, 500000, cycles a key level must hold stable to count as a press or release (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 150000000, maximum cycles allowed in WAIT_PRESS per step (3 s at 50 MHz).
- ADDR_W, 5, sequence RAM address width (max sequence length 2^ADDR_W).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- KEY  in  4  raw board buttons, active-low, asynchronous; KEY[i] = colour i.
- start  in  1  one-cycle pulse that begins checking a round.
- len  in  ADDR_W+1  number of colours to check, sampled on start.
- seq_addr  out  ADDR_W  sequence RAM read address.
- seq_data  in  2  colour at seq_addr, valid 1 cycle after seq_addr (synchronous RAM).
- busy  out  1  high from accepted start until SUCCESS/FAIL completes.
- round_ok  out  1  one-cycle pulse: whole sequence matched.
- round_err  out  1  one-cycle pulse: wrong colour or timeout.
- timeout  out  1  high with round_err when cause was timeout; held until next accepted start.
- press_led  out  4  one-hot colour currently held and accepted; feeds LEDR[3:0].
- progress  out  ADDR_W+1  number of colours matched this round.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; counters 0.
- Reset mid-round aborts immediately. No pulse is emitted.
- KEY passes through a 2-FF synchroniser, then is inverted to k[3:0] (1 = pressed). Synchroniser latency is 2 cycles.
- States: IDLE, FETCH, WAIT_PRESS, DEB_PRESS, COMPARE, WAIT_RELEASE, DEB_RELEASE, SUCCESS, FAIL.
- IDLE:
  - start=1 → latch len, clear idx, progress and timeout, set busy.
  - If len=0 → SUCCESS; else → FETCH.
  - start while busy is ignored.
- FETCH: drive seq_addr=idx for 1 cycle; latch seq_data into exp on the next cycle; → WAIT_PRESS.
- WAIT_PRESS:
  - Timeout counter increments each cycle; it clears on entry.
  - When k is one-hot, capture it into cand → DEB_PRESS.
  - k with 0 or ≥2 bits set is ignored.
  - Counter reaching TIMEOUT_CYCLES-1 → FAIL with timeout=1.
- DEB_PRESS:
  - k must equal cand for DEB_CYCLES consecutive cycles → COMPARE.
  - Any difference → WAIT_PRESS. The timeout counter resumes; it is not cleared.
- COMPARE (1 cycle):
  - cand == one-hot(exp) → WAIT_RELEASE and set press_led=cand.
  - Mismatch → FAIL.
- WAIT_RELEASE: press_led stays at cand; k==0 → DEB_RELEASE. No timeout applies while the key is held.
- DEB_RELEASE:
  - k==0 for DEB_CYCLES cycles → clear press_led, idx++, progress++.
  - Then if idx==len → SUCCESS, else → FETCH.
  - Any k≠0 → WAIT_RELEASE.
- SUCCESS: round_ok=1 for 1 cycle, busy=0 → IDLE.
- FAIL: round_err=1 for 1 cycle, press_led=0, busy=0 → IDLE. A held key does not re-trigger anything because IDLE ignores keys.
- Latency from end of release debounce to the next colour being armed: 2 cycles (FETCH + data).
- progress saturates at len. Maximum len = 2^ADDR_W; idx does not wrap within a round.

Test Plan (DEB_CYCLES=4, TIMEOUT_CYCLES=100, ADDR_W=3, RAM model {2,0,3}):
- start, len=3; press KEY[2], KEY[0], KEY[3], each held 10 cycles, released 10 cycles → press_led=0100, 0001, 1000 in turn; progress 1,2,3; one round_ok pulse; busy falls the same cycle.
- start, len=2; press KEY[2], then KEY[1] → round_err pulse after the KEY[1] debounce; timeout=0; progress=1.
- start, len=1; no key for 100 cycles → round_err and timeout=1 in the 100th WAIT_PRESS cycle; busy=0.
- start, len=1; KEY[2] bounces low 2 cycles, high 1, low 10 → exactly one accepted press; round_ok; no round_err.
- start, len=1; KEY[2] and KEY[1] pressed together, then KEY[1] released → press accepted only once one-hot; round_ok.
- RESET asserted mid WAIT_RELEASE → all outputs 0 immediately; a second start with len=0 → round_ok 2 cycles later.
